crossing_gate_scheduler: RTL
============================

# crossing_gate_scheduler

Per-crossing gate sequencer that consumes the voted `train_detected` / `train_exited` vectors from the sensor fusion stage. It drives warning lights and schedules gate lower/raise commands onto a single shared gate-actuator channel using round-robin arbitration. Warning time scales with weather mode. Actuator timeouts latch a fail-safe fault per crossing.

## Interface
- `NUM_CROSSINGS`, 4: number of crossings; `ID_W = $clog2(NUM_CROSSINGS)`, minimum 1.
- `WARN_CYCLES`, 16: base warning duration before a lower request.
- `CLEAR_CYCLES`, 8: minimum hold after train exit before a raise request.
- `ACT_TIMEOUT`, 64: maximum cycles from command acceptance to `act_done`.
- `CNT_W`, 10: timer width; must hold `WARN_CYCLES*4` and `ACT_TIMEOUT`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `train_detected` in N: voted presence, level.
- `train_exited` in N: one-cycle exit pulse.
- `weather_mode` in 2: 0 clear, 1 rain, 2 fog, 3 storm.
- `act_valid` out 1: command pending on the shared channel.
- `act_ready` in 1: actuator accepts the command.
- `act_id` out ID_W: target crossing.
- `act_lower` out 1: 1 = lower, 0 = raise.
- `act_done` in 1: completion pulse.
- `act_done_id` in ID_W: crossing reported by `act_done`.
- `fault_clr` in 1: clears faulted crossings.
- `warn_lights` out N: lights on.
- `gate_closed` out N: gate confirmed down.
- `fault` out N: latched actuator fault.

## Operation
- Per-crossing FSM:
  - IDLE: go to WARN on `train_detected`.
  - WARN: count down `warn_len`, then go to LOWER_REQ.
  - LOWER_REQ: when the command is accepted (`act_valid & act_ready`), go to LOWER_WAIT.
  - LOWER_WAIT: on matching `act_done`, go to CLOSED.
  - CLOSED: when `exit_seen` is set and `!train_detected`, go to CLEAR.
  - CLEAR: count `CLEAR_CYCLES`, then go to RAISE_REQ.
  - RAISE_REQ: on acceptance, go to RAISE_WAIT.
  - RAISE_WAIT: on matching `act_done`, go to IDLE, or to LOWER_REQ if `relower` is set.
  - FAULT: go to IDLE on `fault_clr & !train_detected`.
- `warn_len` is sampled at WARN entry from `weather_mode`: 0 gives `WARN_CYCLES`, 1 and 2 give `WARN_CYCLES<<1`, 3 gives `WARN_CYCLES<<2`.
- `exit_seen`: cleared on WARN entry, then set by any `train_exited` pulse. This keeps exits that arrive before CLOSED.
- Re-detection:
  - In CLEAR: return to CLOSED and clear `exit_seen`.
  - In RAISE_REQ or RAISE_WAIT: set `relower`. The raise command is never withdrawn.
- Timeout: the timer runs only in LOWER_WAIT and RAISE_WAIT. Reaching `ACT_TIMEOUT` with no matching done sends the crossing to FAULT. If done arrives in the same cycle as expiry, done wins.
- `act_done` whose id is not in a WAIT state is ignored.
- Arbiter:
  - Round-robin over crossings in LOWER_REQ or RAISE_REQ, searching from `rr_ptr`.
  - Once `act_valid` is high, `act_id` and `act_lower` stay stable until acceptance.
  - On acceptance, `rr_ptr` becomes granted id + 1, wrapping to 0.
  - Only one command is accepted per cycle.
- Outputs:
  - `warn_lights[i]` = 1 in every state except IDLE, including FAULT (fail-safe).
  - `gate_closed[i]` = 1 only in CLOSED and CLEAR.
  - `fault[i]` = 1 in FAULT.

## Timing
- Reset values:
  - All FSMs in IDLE; `rr_ptr` = 0.
  - Outputs `warn_lights`, `gate_closed`, `fault` = 0.
  - Outputs `act_valid`, `act_lower` = 0; `act_id` = 0.
- Reset mid-operation returns every crossing to IDLE immediately and drops `act_valid`.
- All outputs are registered.
- Detection at cycle t: state is WARN at t+1 and `warn_lights` is high at t+1.
- WARN lasts exactly `warn_len` cycles. `act_valid` for that crossing is asserted `warn_len`+1 cycles after WARN entry at the earliest.
- `act_valid` rises at the earliest one cycle after the crossing enters a REQ state. It can assert back-to-back after an acceptance if other requests are pending.
- Matching `act_done` at cycle t: the new state and `gate_closed` are visible at t+1.

## Structure
- Package `crossing_pkg` holds the state enum (9 states, 4 bits) and the weather-mode localparams. It is shared with the voter.
- Sub-module `crossing_gate_fsm` is one per crossing, created with a generate loop. It holds the timer, `exit_seen` and `relower`, and exposes `req`/`req_lower`/`grant_accept`/`done`.
- The top level holds the round-robin arbiter and output muxing.

## Test plan
- Clear weather, crossing 0: detect → `act_valid` with id 0, lower=1 after 17 cycles. Ready → done → `gate_closed[0]`=1. Exit pulse, detect low → raise after 8 cycles → done → IDLE, lights off.
- Storm: `weather_mode`=3 → WARN lasts 64 cycles. Changing mode mid-WARN has no effect.
- Crossings 0–3 detected in the same cycle, `act_ready` held low 5 cycles then high → grants in order 0,1,2,3. `act_id` is stable while stalled.
- No `act_done` after a lower command is accepted → `fault` high after 64 cycles, lights stay on. `fault_clr` with detect low → IDLE.
- Exit pulse during LOWER_WAIT → remembered; CLEAR is entered immediately after done.
- Re-detect during RAISE_WAIT → after done, crossing goes to LOWER_REQ with no warn delay. `rst_n` low mid-sequence → all outputs zero.

Source files
------------

// File: rtl/crossing_pkg.sv
// Shared types for the crossing gate logic: per-crossing state encoding and
// weather-mode codes. Also consumed by the sensor voter.
package crossing_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WARN       = 4'd1,
    ST_LOWER_REQ  = 4'd2,
    ST_LOWER_WAIT = 4'd3,
    ST_CLOSED     = 4'd4,
    ST_CLEAR      = 4'd5,
    ST_RAISE_REQ  = 4'd6,
    ST_RAISE_WAIT = 4'd7,
    ST_FAULT      = 4'd8
  } cg_state_e;

  localparam logic [1:0] WX_CLEAR = 2'd0;
  localparam logic [1:0] WX_RAIN  = 2'd1;
  localparam logic [1:0] WX_FOG   = 2'd2;
  localparam logic [1:0] WX_STORM = 2'd3;

  // Left-shift applied to the base warning time for a weather mode.
  function automatic int unsigned wx_shift(input logic [1:0] wm);
    case (wm)
      WX_CLEAR:        return 0;
      WX_RAIN, WX_FOG: return 1;
      default:         return 2;
    endcase
  endfunction

endpackage

// File: rtl/crossing_gate_fsm.sv
// One crossing's gate sequencer: warning timer, actuator request/wait with
// timeout, exit tracking and re-lower on re-detection. Outputs are registered
// from the next state so they line up with the state register.
module crossing_gate_fsm
  import crossing_pkg::*;
#(
  parameter int WARN_CYCLES  = 16,
  parameter int CLEAR_CYCLES = 8,
  parameter int ACT_TIMEOUT  = 64,
  parameter int CNT_W        = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       detected_i,
  input  logic       exited_i,
  input  logic [1:0] weather_i,
  input  logic       grant_accept_i,
  input  logic       done_i,
  input  logic       fault_clr_i,
  output logic       req_o,
  output logic       req_lower_o,
  output logic       light_o,
  output logic       closed_o,
  output logic       fault_o
);

  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(ACT_TIMEOUT - 1);

  cg_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exit_q, exit_d;
  logic             relower_q, relower_d;
  logic             req_q, req_lower_q, light_q, closed_q, fault_q;

  // Last count value of the warning phase, frozen at WARN entry.
  function automatic logic [CNT_W-1:0] warn_last(input logic [1:0] wm);
    return CNT_W'((WARN_CYCLES << wx_shift(wm)) - 1);
  endfunction

  // Next-state, timer, exit memory and re-lower flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exit_d    = exit_q;
    relower_d = relower_q;
    case (state_q)
      ST_IDLE: if (detected_i) begin
        state_d   = ST_WARN;
        cnt_d     = warn_last(weather_i);
        exit_d    = 1'b0;
        relower_d = 1'b0;
      end
      ST_WARN: begin
        if (cnt_q == '0) state_d = ST_LOWER_REQ;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_LOWER_REQ: if (grant_accept_i) begin
        state_d = ST_LOWER_WAIT;
        cnt_d   = '0;
      end
      ST_LOWER_WAIT: begin
        if (done_i)                state_d = ST_CLOSED;
        else if (cnt_q == TO_LAST) state_d = ST_FAULT;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      ST_CLOSED: if ((exit_q || exited_i) && !detected_i) begin
        state_d = ST_CLEAR;
        cnt_d   = CLEAR_LAST;
      end
      ST_CLEAR: begin
        // A new train while clearing keeps the gate down and forgets the old exit.
        if (detected_i) begin
          state_d = ST_CLOSED;
          exit_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = ST_RAISE_REQ;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RAISE_REQ: begin
        // The raise still goes out; the gate comes back down straight after.
        if (detected_i) begin
          relower_d = 1'b1;
          exit_d    = 1'b0;
        end
        if (grant_accept_i) begin
          state_d = ST_RAISE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RAISE_WAIT: begin
        if (detected_i) begin
          relower_d = 1'b1;
          exit_d    = 1'b0;
        end
        if (done_i) begin
          state_d   = (relower_q || detected_i) ? ST_LOWER_REQ : ST_IDLE;
          relower_d = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_FAULT;
          relower_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FAULT: if (fault_clr_i && !detected_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Exits are remembered from WARN onward so early exits are not lost.
    if (exited_i && state_q != ST_IDLE) exit_d = 1'b1;
  end

  // State and registered output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      exit_q      <= 1'b0;
      relower_q   <= 1'b0;
      req_q       <= 1'b0;
      req_lower_q <= 1'b0;
      light_q     <= 1'b0;
      closed_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exit_q      <= exit_d;
      relower_q   <= relower_d;
      req_q       <= (state_d == ST_LOWER_REQ) || (state_d == ST_RAISE_REQ);
      req_lower_q <= (state_d == ST_LOWER_REQ);
      light_q     <= (state_d != ST_IDLE);
      closed_q    <= (state_d == ST_CLOSED) || (state_d == ST_CLEAR);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign req_o       = req_q;
  assign req_lower_o = req_lower_q;
  assign light_o     = light_q;
  assign closed_o    = closed_q;
  assign fault_o     = fault_q;

endmodule

// File: rtl/crossing_gate_scheduler.sv
// Crossing gate scheduler: one sequencer per crossing plus a round-robin
// arbiter driving the shared gate-actuator channel. The channel command is
// registered and held stable until the actuator accepts it.
module crossing_gate_scheduler
  import crossing_pkg::*;
#(
  parameter int NUM_CROSSINGS = 4,
  parameter int WARN_CYCLES   = 16,
  parameter int CLEAR_CYCLES  = 8,
  parameter int ACT_TIMEOUT   = 64,
  parameter int CNT_W         = 10,
  parameter int ID_W          = (NUM_CROSSINGS > 1) ? $clog2(NUM_CROSSINGS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CROSSINGS-1:0] train_detected,
  input  logic [NUM_CROSSINGS-1:0] train_exited,
  input  logic [1:0]               weather_mode,
  output logic                     act_valid,
  input  logic                     act_ready,
  output logic [ID_W-1:0]          act_id,
  output logic                     act_lower,
  input  logic                     act_done,
  input  logic [ID_W-1:0]          act_done_id,
  input  logic                     fault_clr,
  output logic [NUM_CROSSINGS-1:0] warn_lights,
  output logic [NUM_CROSSINGS-1:0] gate_closed,
  output logic [NUM_CROSSINGS-1:0] fault
);

  localparam int IW1 = ID_W + 1;

  logic [NUM_CROSSINGS-1:0] req, req_lower, grant, done_v;
  logic                     act_valid_q, act_lower_q;
  logic [ID_W-1:0]          act_id_q, rr_ptr_q;

  logic                     accept;
  logic [ID_W-1:0]          nxt_ptr, ptr_eff, pick_id;
  logic [NUM_CROSSINGS-1:0] mask;
  logic                     pick_vld, pick_lower;

  for (genvar g = 0; g < NUM_CROSSINGS; g++) begin : g_xing
    assign grant[g]  = accept && (act_id_q == ID_W'(g));
    assign done_v[g] = act_done && (act_done_id == ID_W'(g));

    crossing_gate_fsm #(
      .WARN_CYCLES (WARN_CYCLES),
      .CLEAR_CYCLES(CLEAR_CYCLES),
      .ACT_TIMEOUT (ACT_TIMEOUT),
      .CNT_W       (CNT_W)
    ) u_fsm (
      .clk           (clk),
      .rst_n         (rst_n),
      .detected_i    (train_detected[g]),
      .exited_i      (train_exited[g]),
      .weather_i     (weather_mode),
      .grant_accept_i(grant[g]),
      .done_i        (done_v[g]),
      .fault_clr_i   (fault_clr),
      .req_o         (req[g]),
      .req_lower_o   (req_lower[g]),
      .light_o       (warn_lights[g]),
      .closed_o      (gate_closed[g]),
      .fault_o       (fault[g])
    );
  end

  assign accept  = act_valid_q && act_ready;
  assign nxt_ptr = (act_id_q == ID_W'(NUM_CROSSINGS - 1)) ? '0 : act_id_q + 1'b1;

  // Round-robin pick. On an acceptance cycle the granted crossing still shows
  // req, so it is masked out and the search starts just past it.
  always_comb begin
    ptr_eff    = accept ? nxt_ptr : rr_ptr_q;
    mask       = req;
    if (accept) mask[act_id_q] = 1'b0;
    pick_vld   = 1'b0;
    pick_id    = '0;
    pick_lower = 1'b0;
    for (int k = 0; k < NUM_CROSSINGS; k++) begin
      logic [IW1-1:0] s;
      s = {1'b0, ptr_eff} + IW1'(k);
      if (s >= IW1'(NUM_CROSSINGS)) s = s - IW1'(NUM_CROSSINGS);
      if (!pick_vld && mask[s[ID_W-1:0]]) begin
        pick_vld   = 1'b1;
        pick_id    = s[ID_W-1:0];
        pick_lower = req_lower[s[ID_W-1:0]];
      end
    end
  end

  // Channel register: load a new command only when idle or just accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_valid_q <= 1'b0;
      act_id_q    <= '0;
      act_lower_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      if (accept) rr_ptr_q <= nxt_ptr;
      if (!act_valid_q || accept) begin
        act_valid_q <= pick_vld;
        if (pick_vld) begin
          act_id_q    <= pick_id;
          act_lower_q <= pick_lower;
        end
      end
    end
  end

  assign act_valid = act_valid_q;
  assign act_id    = act_id_q;
  assign act_lower = act_lower_q;

endmodule
